// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage register: state encoding,
// NOP control constant and payload width helper.
package pipe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t EMPTY = 2'd0;
  localparam state_t FULL  = 2'd1;
  localparam state_t SKID  = 2'd2;

  // Wide enough for any control word; callers take the low CTRL_BITS.
  localparam int unsigned NOP_CTRL_MAX = 256;
  localparam logic [NOP_CTRL_MAX-1:0] NOP_CTRL = '0;

  function automatic int unsigned payload_bits(input int unsigned ctrl_bits,
                                               input int unsigned data_bits,
                                               input int unsigned lanes);
    return ctrl_bits + data_bits * lanes;
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-loaded, synchronously reset payload register (ctrl word + data lanes).
module pipe_payload_reg #(
  parameter int unsigned WIDTH = 176
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage with stall, flush and sync reset.
// Define PIPE_STAGE_SKID_EN to add a skid register and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned LANES     = 5,
  parameter int unsigned CTRL_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_BITS-1:0]       in_ctrl,
  input  logic [DATA_BITS*LANES-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_BITS-1:0]       out_ctrl,
  output logic [DATA_BITS*LANES-1:0] out_data
);

  localparam int unsigned PW = payload_bits(CTRL_BITS, DATA_BITS, LANES);

  state_t          state, state_nxt;
  logic            in_fire, out_fire;
  logic            main_en;
  logic [PW-1:0]   main_d, main_q;
`ifdef PIPE_STAGE_SKID_EN
  logic            skid_en;
  logic [PW-1:0]   skid_q;
`endif

  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready = (state != SKID);
`else
  assign in_ready = !out_valid || out_ready;
`endif

  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    main_d    = {in_ctrl, in_data};
`ifdef PIPE_STAGE_SKID_EN
    skid_en   = 1'b0;
`endif
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt = FULL;
          main_en   = 1'b1;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end
`ifdef PIPE_STAGE_SKID_EN
        else if (in_fire) begin
          state_nxt = SKID;
          skid_en   = 1'b1;
        end
`endif
        else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
`ifdef PIPE_STAGE_SKID_EN
      SKID: begin
        if (out_fire) begin
          state_nxt = FULL;
          main_en   = 1'b1;
          main_d    = skid_q;
        end
      end
`endif
      default: state_nxt = EMPTY;
    endcase
    // Flush drops the stage and any same-cycle accept; data may stay stale.
    if (flush) begin
      state_nxt = EMPTY;
      main_en   = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_en   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  pipe_payload_reg #(.WIDTH(PW)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_payload_reg #(.WIDTH(PW)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   ({in_ctrl, in_data}),
    .q   (skid_q)
  );
`endif

  assign out_ctrl = out_valid ? main_q[PW-1 -: CTRL_BITS] : NOP_CTRL[CTRL_BITS-1:0];
  assign out_data = main_q[DATA_BITS*LANES-1:0];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based occupancy model.
module tb_pipe_stage_reg;

  localparam int DB = 32;
  localparam int LN = 5;
  localparam int CB = 16;
  localparam int DW = DB * LN;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [CB-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CB-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  logic [DW-1:0] seen[$];
  logic obs_ready, exp_ready;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_BITS(DB), .LANES(LN), .CTRL_BITS(CB)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
  );

  function automatic logic [DW-1:0] mk_data(input logic [31:0] pc);
    logic [DW-1:0] d;
    d = '0;
    d[31:0] = pc;
    for (int k = 1; k < LN; k++) d[k*DB +: DB] = $urandom;
    return d;
  endfunction

  // One clock: drive, sample in_ready, record output transfers, advance model.
  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [CB-1:0] c, input logic [DW-1:0] d,
                       input logic ordy);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
    #1;
    obs_ready = in_ready;
    exp_ready = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ordy);
    if (out_valid === 1'b1 && ordy) seen.push_back(out_data);
    @(posedge clk);
    if (r || f) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (iv && exp_ready) q.push_back('{c: c, d: d});
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 16'hBEEF, mk_data(32'h100), 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", out_ctrl); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", obs_ready); end
  endtask

  task automatic test_stream();
    logic [CB-1:0] c;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d[3];
    seen.delete();
    for (int i = 0; i < 5; i++) begin
      c = 16'h0010 + 16'(i);
      d = mk_data(32'(4 * i));
      if (i < 3) exp_d[i] = d;
      cycle(1'b0, 1'b0, i < 3, c, d, 1'b1);
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", i, obs_ready, exp_ready); end
      checks++; if (out_valid !== (i < 3)) begin errors++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, out_valid, i < 3); end
      if (i < 3) begin
        checks++; if (out_ctrl !== c || out_data !== exp_d[i]) begin errors++; $display("FAIL stream_out cyc=%0d got=%h/%h exp=%h/%h", i, out_ctrl, out_data, c, exp_d[i]); end
      end else begin
        checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL stream_bubble cyc=%0d got=%h exp=0", i, out_ctrl); end
      end
    end
    checks++; if (seen.size() != 3) begin errors++; $display("FAIL stream_count got=%0d exp=3", seen.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (seen[i] !== exp_d[i]) begin errors++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, seen[i], exp_d[i]); end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] a, b;
    a = mk_data(32'h200);
    b = mk_data(32'h204);
    seen.delete();
    cycle(1'b0, 1'b0, 1'b1, 16'h00A1, a, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 16'h00B2, b, 1'b0);
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b exp=%b", i, obs_ready, exp_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== a) begin errors++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, a); end
      if (i > 0 || CAP == 1) begin
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL stall_blocked cyc=%0d got=%b exp=0", i, obs_ready); end
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 16'h00B2, b, 1'b1);
    checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL release_ready got=%b exp=%b", obs_ready, exp_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== b || out_ctrl !== 16'h00B2) begin errors++; $display("FAIL release_b got=%b/%h exp=1/%h", out_valid, out_data, b); end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_drain got=%b exp=0", out_valid); end
    checks++; if (seen.size() != 2) begin errors++; $display("FAIL stall_count got=%0d exp=2", seen.size()); end
    else begin
      checks++; if (seen[0] !== a || seen[1] !== b) begin errors++; $display("FAIL stall_order got=%h,%h exp=%h,%h", seen[0], seen[1], a, b); end
    end
  endtask

  task automatic test_flush();
    seen.delete();
    cycle(1'b0, 1'b0, 1'b1, 16'h0C01, mk_data(32'h300), 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0C02, mk_data(32'h304), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 16'h0C03, mk_data(32'h308), 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL flush_ctrl got=%h exp=0", out_ctrl); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL flush_ready cyc=%0d got=%b exp=1", i, obs_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak cyc=%0d got=%b exp=0", i, out_valid); end
    end
    checks++; if (seen.size() != 0) begin errors++; $display("FAIL flush_seen got=%0d exp=0", seen.size()); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, 1'b1, 16'h0D01, mk_data(32'h400), 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0D02, mk_data(32'h404), 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 16'h0D03, mk_data(32'h408), 1'b0);
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin errors++; $display("FAIL rstmid_out got=%b/%h/%h exp=0/0/0", out_valid, out_ctrl, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready2 got=%b exp=1", obs_ready); end
  endtask

  task automatic test_random();
    logic [CB-1:0] c;
    logic          f, iv, ordy;
    int            bad = 0;
    for (int i = 0; i < 400; i++) begin
      c    = 16'($urandom) | 16'h1;
      f    = ($urandom_range(0, 19) == 0);
      iv   = $urandom_range(0, 1);
      ordy = ($urandom_range(0, 9) < 6);
      cycle(1'b0, f, iv, c, mk_data($urandom), ordy);
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, obs_ready, exp_ready);
      end
      checks++;
      if (out_valid !== (q.size() > 0) ||
          (q.size() > 0 && (out_ctrl !== q[0].c || out_data !== q[0].d)) ||
          (q.size() == 0 && out_ctrl !== '0)) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_out cyc=%0d got=%b/%h exp_valid=%b", i, out_valid, out_ctrl, q.size() > 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
